// File: rtl/alu_issue.sv
// Execute-stage issue/retire wrapper: decodes MIPS ALU instructions into S1, drives the
// external combinational ALU, captures results into S2 and raises precise exceptions.
module alu_issue #(
    parameter bit OVF_TRAP = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    input  logic        i_flush,
    output logic [31:0] o_alu_op_1,
    output logic [31:0] o_alu_op_2,
    output logic [3:0]  o_alu_op,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_exception,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_reg,
    output logic        o_wb_en,
    output logic        o_exc_valid,
    output logic [4:0]  o_exc_code,
    output logic [31:0] o_exc_epc,
    input  logic        i_exc_ack
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 4;
    localparam int unsigned REGW = 5;
    localparam int unsigned EXCW = 5;

    localparam logic [OPW-1:0]  OP_SLL  = 4'h0;
    localparam logic [OPW-1:0]  OP_SRL  = 4'h1;
    localparam logic [OPW-1:0]  OP_SRA  = 4'h2;
    localparam logic [OPW-1:0]  OP_ADD  = 4'h3;
    localparam logic [OPW-1:0]  OP_ADDU = 4'h4;
    localparam logic [OPW-1:0]  OP_SUB  = 4'h5;
    localparam logic [OPW-1:0]  OP_AND  = 4'h7;
    localparam logic [OPW-1:0]  OP_OR   = 4'h8;
    localparam logic [OPW-1:0]  OP_XOR  = 4'h9;
    localparam logic [OPW-1:0]  OP_SLT  = 4'hb;
    localparam logic [OPW-1:0]  OP_SLTU = 4'hc;
    localparam logic [OPW-1:0]  OP_LUI  = 4'hd;

    localparam logic [EXCW-1:0] EXC_RI  = 5'd10;
    localparam logic [EXCW-1:0] EXC_OV  = 5'd12;

    typedef enum logic {ST_RUN, ST_EXC} state_t;

    state_t            state_q, state_d;
    logic              s1_valid_q, s1_valid_d;
    logic [XLEN-1:0]   s1_op1_q, s1_op1_d;
    logic [XLEN-1:0]   s1_op2_q, s1_op2_d;
    logic [OPW-1:0]    s1_op_q, s1_op_d;
    logic [REGW-1:0]   s1_dst_q, s1_dst_d;
    logic [XLEN-1:0]   s1_pc_q, s1_pc_d;
    logic              s1_ill_q, s1_ill_d;
    logic              s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]   s2_data_q, s2_data_d;
    logic [REGW-1:0]   s2_reg_q, s2_reg_d;
    logic              s2_wen_q, s2_wen_d;
    logic [EXCW-1:0]   exc_code_q, exc_code_d;
    logic [XLEN-1:0]   exc_epc_q, exc_epc_d;

    logic [XLEN-1:0]   dec_op1, dec_op2;
    logic [OPW-1:0]    dec_op;
    logic [REGW-1:0]   dec_dst;
    logic              dec_ill;

    logic [5:0]        opcode, funct;
    logic [XLEN-1:0]   imm_sext, imm_zext;
    logic              unused_rs_field;

    logic              s2_free_c, in_ready_c, accept_c, move_c, trap_c;
    logic              is_add_c, is_sub_c, sign_ovf_c, ovf_c, zero_shift_c;

    assign opcode          = i_instr[31:26];
    assign funct           = i_instr[5:0];
    assign imm_sext        = {{16{i_instr[15]}}, i_instr[15:0]};
    assign imm_zext        = XLEN'(i_instr[15:0]);
    // Operand values arrive pre-read, so the rs specifier field is not needed here.
    assign unused_rs_field = ^i_instr[25:21];

    // Instruction decode into ALU code, operands and destination.
    always_comb begin
        dec_op1 = i_rs_val;
        dec_op2 = i_rt_val;
        dec_op  = OP_SLL;
        dec_dst = i_instr[15:11];
        dec_ill = 1'b0;
        if (opcode == 6'h00) begin
            case (funct)
                6'h00: begin dec_op = OP_SLL; dec_op1 = i_rt_val; dec_op2 = XLEN'(i_instr[10:6]); end
                6'h02: begin dec_op = OP_SRL; dec_op1 = i_rt_val; dec_op2 = XLEN'(i_instr[10:6]); end
                6'h03: begin dec_op = OP_SRA; dec_op1 = i_rt_val; dec_op2 = XLEN'(i_instr[10:6]); end
                6'h04: begin dec_op = OP_SLL; dec_op1 = i_rt_val; dec_op2 = XLEN'(i_rs_val[4:0]); end
                6'h06: begin dec_op = OP_SRL; dec_op1 = i_rt_val; dec_op2 = XLEN'(i_rs_val[4:0]); end
                6'h07: begin dec_op = OP_SRA; dec_op1 = i_rt_val; dec_op2 = XLEN'(i_rs_val[4:0]); end
                6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27: dec_op = OP_ADD + {1'b0, funct[2:0]};
                6'h2a: dec_op = OP_SLT;
                6'h2b: dec_op = OP_SLTU;
                default: dec_ill = 1'b1;
            endcase
        end else begin
            dec_dst = i_instr[20:16];
            case (opcode)
                6'h08: begin dec_op = OP_ADD;  dec_op2 = imm_sext; end
                6'h09: begin dec_op = OP_ADDU; dec_op2 = imm_sext; end
                6'h0a: begin dec_op = OP_SLT;  dec_op2 = imm_sext; end
                6'h0b: begin dec_op = OP_SLTU; dec_op2 = imm_sext; end
                6'h0c: begin dec_op = OP_AND;  dec_op2 = imm_zext; end
                6'h0d: begin dec_op = OP_OR;   dec_op2 = imm_zext; end
                6'h0e: begin dec_op = OP_XOR;  dec_op2 = imm_zext; end
                6'h0f: begin dec_op = OP_LUI;  dec_op2 = imm_zext; end
                default: dec_ill = 1'b1;
            endcase
        end
        if (dec_ill) begin
            dec_op  = OP_SLL;
            dec_op1 = '0;
            dec_op2 = '0;
            dec_dst = '0;
        end
    end

    // Handshake, overflow detection and trap qualification for the S1 instruction.
    always_comb begin
        s2_free_c    = !s2_valid_q || i_out_ready;
        in_ready_c   = !i_rst && (state_q == ST_RUN) && (!s1_valid_q || s2_free_c);
        accept_c     = i_in_valid && in_ready_c;
        is_add_c     = (s1_op_q == OP_ADD);
        is_sub_c     = (s1_op_q == OP_SUB);
        sign_ovf_c   = 1'b0;
        if (is_add_c)
            sign_ovf_c = (s1_op1_q[31] == s1_op2_q[31]) && (i_alu_result[31] != s1_op1_q[31]);
        else if (is_sub_c)
            sign_ovf_c = (s1_op1_q[31] != s1_op2_q[31]) && (i_alu_result[31] != s1_op1_q[31]);
        ovf_c        = (is_add_c || is_sub_c) && (i_alu_exception || sign_ovf_c);
        trap_c       = s1_valid_q && (s1_ill_q || (OVF_TRAP && ovf_c));
        move_c       = s1_valid_q && s2_free_c && !trap_c;
        zero_shift_c = (s1_op_q <= OP_SRA) && (s1_op2_q[4:0] == 5'd0);
    end

    // Next state for the FSM and both pipeline entries.
    always_comb begin
        state_d    = state_q;
        s1_valid_d = s1_valid_q;
        s1_op1_d   = s1_op1_q;
        s1_op2_d   = s1_op2_q;
        s1_op_d    = s1_op_q;
        s1_dst_d   = s1_dst_q;
        s1_pc_d    = s1_pc_q;
        s1_ill_d   = s1_ill_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_reg_d   = s2_reg_q;
        s2_wen_d   = s2_wen_q;
        exc_code_d = exc_code_q;
        exc_epc_d  = exc_epc_q;

        if (accept_c) begin
            s1_valid_d = 1'b1;
            s1_op1_d   = dec_op1;
            s1_op2_d   = dec_op2;
            s1_op_d    = dec_op;
            s1_dst_d   = dec_dst;
            s1_pc_d    = i_pc;
            s1_ill_d   = dec_ill;
        end else if (move_c || trap_c) begin
            s1_valid_d = 1'b0;
        end

        if (move_c) begin
            s2_valid_d = 1'b1;
            s2_data_d  = zero_shift_c ? s1_op1_q : i_alu_result;
            s2_reg_d   = s1_dst_q;
            s2_wen_d   = (s1_dst_q != '0);
        end else if (i_out_ready) begin
            s2_valid_d = 1'b0;
        end

        // A new trap outranks an acknowledge arriving in the same cycle.
        if (trap_c) begin
            state_d    = ST_EXC;
            exc_code_d = s1_ill_q ? EXC_RI : EXC_OV;
            exc_epc_d  = s1_pc_q;
        end else if ((state_q == ST_EXC) && i_exc_ack) begin
            state_d = ST_RUN;
        end

        if (i_flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            state_d    = ST_RUN;
        end
    end

    // State registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_RUN;
            s1_valid_q <= 1'b0;
            s1_op1_q   <= '0;
            s1_op2_q   <= '0;
            s1_op_q    <= '0;
            s1_dst_q   <= '0;
            s1_pc_q    <= '0;
            s1_ill_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_reg_q   <= '0;
            s2_wen_q   <= 1'b0;
            exc_code_q <= '0;
            exc_epc_q  <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_op1_q   <= s1_op1_d;
            s1_op2_q   <= s1_op2_d;
            s1_op_q    <= s1_op_d;
            s1_dst_q   <= s1_dst_d;
            s1_pc_q    <= s1_pc_d;
            s1_ill_q   <= s1_ill_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_reg_q   <= s2_reg_d;
            s2_wen_q   <= s2_wen_d;
            exc_code_q <= exc_code_d;
            exc_epc_q  <= exc_epc_d;
        end
    end

    assign o_in_ready  = in_ready_c;
    assign o_alu_op_1  = s1_op1_q;
    assign o_alu_op_2  = s1_op2_q;
    assign o_alu_op    = s1_op_q;
    assign o_out_valid = s2_valid_q;
    assign o_wb_data   = s2_data_q;
    assign o_wb_reg    = s2_reg_q;
    assign o_wb_en     = s2_wen_q;
    assign o_exc_valid = (state_q == ST_EXC);
    assign o_exc_code  = exc_code_q;
    assign o_exc_epc   = exc_epc_q;

endmodule
